// File: rtl/connect6_pkg.sv
// Shared constants for the Connect-6 board path: board geometry, cell colours,
// board-access FSM state encodings and small helpers.
package connect6_pkg;

    localparam int unsigned BRD_SIZE = 19;
    localparam int unsigned NUM_DIAG = 2 * BRD_SIZE - 1;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_BLACK = 2'd1;
    localparam logic [1:0] CELL_WHITE = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [3:0] MASK_ALL  = 4'b1111;
    localparam logic [3:0] MASK_DIAG = 4'b1100;

    function automatic logic move_valid(input logic [4:0] x, input logic [4:0] y,
                                        input logic [1:0] color);
        return (x < 5'(BRD_SIZE)) && (y < 5'(BRD_SIZE)) &&
               (color inside {CELL_EMPTY, CELL_BLACK, CELL_WHITE});
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/scan_index_gen.sv
// Line-index sequencer for a full board scan: k counter with hold/advance,
// row/column clamp, direction-valid mask and last-index flag.
module scan_index_gen
    import connect6_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       active_i,
    input  logic       hold_i,
    output logic       issue_o,
    output logic [5:0] idx_o,
    output logic [4:0] rowcol_o,
    output logic [3:0] mask_o,
    output logic       last_o
);

    logic [5:0] k_q, k_d;

    // The first read is issued on the same edge that enters SCAN, so index 0
    // is forced while starting rather than waiting for the counter.
    assign issue_o  = (start_i || active_i) && !hold_i;
    assign idx_o    = start_i ? '0 : k_q;
    assign last_o   = issue_o && (idx_o == 6'(NUM_DIAG - 1));
    assign rowcol_o = (idx_o < 6'(BRD_SIZE)) ? idx_o[4:0] : '0;
    assign mask_o   = (idx_o < 6'(BRD_SIZE)) ? MASK_ALL : MASK_DIAG;

    always_comb begin
        k_d = k_q;
        if (start_i) begin
            k_d = '0;
        end
        if (issue_o) begin
            k_d = last_o ? '0 : idx_o + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/board_access_ctrl.sv
// Board memory arbiter: single-cell move writes vs. full-board line scans.
// Optional macro SCAN_STATS_EN adds a per-scan cycle counter on scan_cycles.
module board_access_ctrl
    import connect6_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mv_req,
    input  logic [4:0]  mv_x,
    input  logic [4:0]  mv_y,
    input  logic [1:0]  mv_color,
    output logic        mv_ack,
    output logic        mv_err,
    input  logic        scan_start,
    input  logic        hold,
    output logic        scan_busy,
    output logic        scan_done,
    output logic        mem_ena_read,
    output logic        mem_ena_write,
    output logic [4:0]  mem_xloc,
    output logic [4:0]  mem_yloc,
    output logic [1:0]  mem_data_write,
    output logic [4:0]  mem_row,
    output logic [4:0]  mem_col,
    output logic [5:0]  mem_diag_nw,
    output logic [5:0]  mem_diag_ne,
    output logic        line_valid,
    output logic [5:0]  line_idx,
    output logic [3:0]  line_mask,
    output logic [15:0] scan_cycles
);

    logic [1:0] state_q, state_d;
    logic       pend_q, pend_d;
    logic       ack_q, ack_d, err_q, err_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic       wr_q, wr_d;
    logic [4:0] xloc_q, xloc_d, yloc_q, yloc_d;
    logic [1:0] wdata_q, wdata_d;
    logic       rd_q, rd_d;
    logic [4:0] rc_q, rc_d;
    logic [5:0] diag_q, diag_d;
    logic [3:0] rmask_q, rmask_d;
    logic       lv_q;
    logic [5:0] lidx_q;
    logic [3:0] lmask_q;

    logic       mv_ok, scan_go, issue, last;
    logic [5:0] idx;
    logic [4:0] rowcol;
    logic [3:0] mask;

    assign mv_ok   = move_valid(mv_x, mv_y, mv_color);
    assign scan_go = (state_q == ST_IDLE) && !mv_req && (scan_start || pend_q);

    scan_index_gen u_idx (
        .clk      (clk),
        .reset    (reset),
        .start_i  (scan_go),
        .active_i (state_q == ST_SCAN),
        .hold_i   (hold),
        .issue_o  (issue),
        .idx_o    (idx),
        .rowcol_o (rowcol),
        .mask_o   (mask),
        .last_o   (last)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        xloc_d  = '0;
        yloc_d  = '0;
        wdata_d = CELL_EMPTY;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mv_req) begin
                    if (scan_start) begin
                        pend_d = 1'b1;
                    end
                    if (mv_ok) begin
                        state_d = ST_WRITE;
                        wr_d    = 1'b1;
                        ack_d   = 1'b1;
                        xloc_d  = mv_x;
                        yloc_d  = mv_y;
                        wdata_d = mv_color;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (scan_go) begin
                    state_d = ST_SCAN;
                    pend_d  = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (scan_start) begin
                    pend_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy stays up through the cycle that carries scan_done.
        busy_d  = (state_d == ST_SCAN) || (state_d == ST_DRAIN) || (state_q == ST_DRAIN);
        rd_d    = issue;
        rc_d    = issue ? rowcol : '0;
        diag_d  = issue ? idx : '0;
        rmask_d = issue ? mask : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            xloc_q  <= '0;
            yloc_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            rc_q    <= '0;
            diag_q  <= '0;
            rmask_q <= '0;
            lv_q    <= 1'b0;
            lidx_q  <= '0;
            lmask_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            xloc_q  <= xloc_d;
            yloc_q  <= yloc_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rc_q    <= rc_d;
            diag_q  <= diag_d;
            rmask_q <= rmask_d;
            lv_q    <= rd_q;
            lidx_q  <= diag_q;
            lmask_q <= rmask_q;
        end
    end

`ifdef SCAN_STATS_EN
    logic [15:0] cnt_q, cnt_d, stat_q, stat_d;

    // The entry edge counts as the first scan cycle, giving 38 for an unstalled scan.
    always_comb begin
        cnt_d  = cnt_q;
        stat_d = stat_q;
        if (scan_go) begin
            cnt_d = 16'd1;
        end else if ((state_q == ST_SCAN) || (state_q == ST_DRAIN)) begin
            cnt_d = sat_inc16(cnt_q);
        end
        if (state_q == ST_DRAIN) begin
            stat_d = sat_inc16(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            stat_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            stat_q <= stat_d;
        end
    end

    assign scan_cycles = stat_q;
`else
    assign scan_cycles = '0;
`endif

    assign mv_ack         = ack_q;
    assign mv_err         = err_q;
    assign scan_busy      = busy_q;
    assign scan_done      = done_q;
    assign mem_ena_write  = wr_q;
    assign mem_xloc       = xloc_q;
    assign mem_yloc       = yloc_q;
    assign mem_data_write = wdata_q;
    assign mem_ena_read   = rd_q;
    assign mem_row        = rc_q;
    assign mem_col        = rc_q;
    assign mem_diag_nw    = diag_q;
    assign mem_diag_ne    = diag_q;
    assign line_valid     = lv_q;
    assign line_idx       = lidx_q;
    assign line_mask      = lmask_q;

endmodule
